// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: runtime baud tick, TX/RX FIFOs, framing FSMs
// with optional parity, 1/2 stop bits, per-word RX error flags and sticky overrun.

module uart_param_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Push on full and pop on empty are dropped without touching state
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_param_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          baud_div,
  input  logic                 loopback,
  input  logic                 wr_uart,
  input  logic [DATA_BITS-1:0] w_data,
  output logic                 tx_full,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rd_uart,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 rx_empty,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_err
);
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned RX_W  = DATA_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } uart_state_t;

  // Baud tick; the divisor is latched at each wrap so changes apply cleanly
  logic [15:0] baud_cnt;
  logic [15:0] div_q;
  logic        tick_c;

  assign tick_c = (baud_cnt == div_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      div_q    <= '0;
    end else if (tick_c) begin
      baud_cnt <= '0;
      div_q    <= baud_div;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_fifo_dout;
  logic                 tx_fifo_empty;
  logic                 tx_pop_c;

  uart_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_uart),
    .pop   (tx_pop_c),
    .din   (w_data),
    .dout  (tx_fifo_dout),
    .empty (tx_fifo_empty),
    .full  (tx_full)
  );

  uart_state_t          tx_state;
  uart_state_t          tx_state_nx;
  logic [OS_W-1:0]      tx_os;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_q;
  logic                 tx_c;
  logic                 tx_shift_c;
  logic                 tx_os_last_c;
  logic                 tx_bits_done_c;
  logic                 tx_stops_done_c;

  assign tx_os_last_c    = tick_c && (tx_os == OS_W'(OVERSAMPLE - 1));
  assign tx_bits_done_c  = (tx_bit == BIT_W'(DATA_BITS - 1));
  assign tx_stops_done_c = (tx_bit == BIT_W'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= ST_IDLE;
    else      tx_state <= tx_state_nx;
  end

  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      ST_IDLE:   if (!tx_fifo_empty) tx_state_nx = ST_START;
      ST_START:  if (tx_os_last_c) tx_state_nx = ST_DATA;
      ST_DATA:   if (tx_os_last_c && tx_bits_done_c)
                   tx_state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tx_os_last_c) tx_state_nx = ST_STOP;
      ST_STOP:   if (tx_os_last_c && tx_stops_done_c)
                   tx_state_nx = tx_fifo_empty ? ST_IDLE : ST_START;
      default:   tx_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_c       = 1'b1;
    tx_pop_c   = 1'b0;
    tx_shift_c = 1'b0;
    case (tx_state)
      ST_IDLE:   tx_pop_c = !tx_fifo_empty;
      ST_START:  tx_c = 1'b0;
      ST_DATA: begin
        tx_c       = tx_shreg[0];
        tx_shift_c = tx_os_last_c;
      end
      ST_PARITY: tx_c = tx_par;
      ST_STOP:   tx_pop_c = tx_os_last_c && tx_stops_done_c && !tx_fifo_empty;
      default:   tx_c = 1'b1;
    endcase
  end

  // Bit timing counters and shifter; tx itself is a flop so reset forces it high at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q     <= 1'b1;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_q <= tx_c;
      if (tx_pop_c) begin
        tx_shreg <= tx_fifo_dout;
        tx_par   <= (^tx_fifo_dout) ^ 1'(PARITY_ODD);
        tx_os    <= '0;
        tx_bit   <= '0;
      end else begin
        if (tx_shift_c) tx_shreg <= tx_shreg >> 1;
        if (tx_state != ST_IDLE && tick_c)
          tx_os <= tx_os_last_c ? '0 : tx_os + OS_W'(1);
        if (tx_os_last_c) begin
          if ((tx_state == ST_DATA && tx_bits_done_c) || tx_state == ST_PARITY)
            tx_bit <= '0;
          else if (tx_state == ST_DATA || tx_state == ST_STOP)
            tx_bit <= tx_bit + BIT_W'(1);
        end
      end
    end
  end

  assign tx = tx_q;

  // ---------------- RX path ----------------
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_prev;
  logic                 rx_in_c;
  logic                 rx_fall_c;
  uart_state_t          rx_state;
  uart_state_t          rx_state_nx;
  logic [OS_W-1:0]      rx_os;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par;
  logic                 rx_half_c;
  logic                 rx_full_c;
  logic                 rx_bits_done_c;
  logic                 rx_data_smp_c;
  logic                 rx_par_smp_c;
  logic                 rx_stop_smp_c;
  logic                 rx_perr_c;
  logic                 rx_push_q;
  logic [RX_W-1:0]      rx_word_q;
  logic [RX_W-1:0]      rx_head;
  logic                 rx_fifo_empty;
  logic                 rx_fifo_full;
  logic                 overrun_q;

  assign rx_in_c        = loopback ? tx_q : rx_s2;
  assign rx_fall_c      = rx_prev && !rx_in_c;
  assign rx_half_c      = tick_c && (rx_os == OS_W'(OVERSAMPLE / 2 - 1));
  assign rx_full_c      = tick_c && (rx_os == OS_W'(OVERSAMPLE - 1));
  assign rx_bits_done_c = (rx_bit == BIT_W'(DATA_BITS - 1));
  assign rx_perr_c      = (PARITY_EN != 0) && ((^rx_shreg) ^ rx_par ^ 1'(PARITY_ODD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= ST_IDLE;
    else      rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      ST_IDLE:   if (rx_fall_c) rx_state_nx = ST_START;
      ST_START:  if (rx_half_c) rx_state_nx = rx_in_c ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_full_c && rx_bits_done_c)
                   rx_state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_full_c) rx_state_nx = ST_STOP;
      ST_STOP:   if (rx_full_c) rx_state_nx = ST_IDLE;
      default:   rx_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_data_smp_c = 1'b0;
    rx_par_smp_c  = 1'b0;
    rx_stop_smp_c = 1'b0;
    case (rx_state)
      ST_DATA:   rx_data_smp_c = rx_full_c;
      ST_PARITY: rx_par_smp_c  = rx_full_c;
      ST_STOP:   rx_stop_smp_c = rx_full_c;
      default:   rx_data_smp_c = 1'b0;
    endcase
  end

  // Sampling is mid-bit: the counter restarts at the half-bit start check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_os     <= '0;
      rx_bit    <= '0;
      rx_shreg  <= '0;
      rx_par    <= 1'b0;
      rx_push_q <= 1'b0;
      rx_word_q <= '0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_in_c;
      rx_push_q <= rx_stop_smp_c;
      if (rx_stop_smp_c) rx_word_q <= {~rx_in_c, rx_perr_c, rx_shreg};
      if (rx_par_smp_c)  rx_par <= rx_in_c;
      if (rx_state == ST_IDLE) begin
        rx_os  <= '0;
        rx_bit <= '0;
      end else if (tick_c) begin
        rx_os <= ((rx_half_c && rx_state == ST_START) || rx_full_c) ? '0 : rx_os + OS_W'(1);
        if (rx_data_smp_c) begin
          rx_shreg <= {rx_in_c, rx_shreg[DATA_BITS-1:1]};
          rx_bit   <= rx_bit + BIT_W'(1);
        end
      end
    end
  end

  uart_param_fifo #(.WIDTH(RX_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_q),
    .pop   (rd_uart),
    .din   (rx_word_q),
    .dout  (rx_head),
    .empty (rx_fifo_empty),
    .full  (rx_fifo_full)
  );

  // A drop in the same cycle as clr_err wins so no lost word goes unreported
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            overrun_q <= 1'b0;
    else if (rx_push_q && rx_fifo_full)  overrun_q <= 1'b1;
    else if (clr_err)                    overrun_q <= 1'b0;
  end

  assign rx_empty   = rx_fifo_empty;
  assign r_data     = rx_fifo_empty ? '0 : rx_head[DATA_BITS-1:0];
  assign parity_err = !rx_fifo_empty && (PARITY_EN != 0) && rx_head[DATA_BITS];
  assign frame_err  = !rx_fifo_empty && rx_head[DATA_BITS+1];
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_param_core.sv
// Scoreboard bench for uart_param_core: default 8N1 instance plus an even-parity instance.
`timescale 1ns/1ps

module tb_uart_param_core;
  logic       clk = 1'b0;
  logic       rst;
  logic [15:0] baud_div, p_baud_div;
  logic       loopback, p_loopback;
  logic       wr_uart, p_wr_uart;
  logic [7:0] w_data, p_w_data;
  logic       tx_full, p_tx_full;
  logic       tx, p_tx;
  logic       rx, p_rx;
  logic       rd_uart, p_rd_uart;
  logic [7:0] r_data, p_r_data;
  logic       rx_empty, p_rx_empty;
  logic       parity_err, p_parity_err;
  logic       frame_err, p_frame_err;
  logic       overrun, p_overrun;
  logic       clr_err, p_clr_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] p_exp_q[$];

  always #5 clk = ~clk;

  uart_param_core u_dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .loopback(loopback),
    .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .tx(tx), .rx(rx),
    .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .clr_err(clr_err)
  );

  uart_param_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
    .clk(clk), .rst(rst), .baud_div(p_baud_div), .loopback(p_loopback),
    .wr_uart(p_wr_uart), .w_data(p_w_data), .tx_full(p_tx_full), .tx(p_tx), .rx(p_rx),
    .rd_uart(p_rd_uart), .r_data(p_r_data), .rx_empty(p_rx_empty),
    .parity_err(p_parity_err), .frame_err(p_frame_err), .overrun(p_overrun),
    .clr_err(p_clr_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    @(posedge clk); #1;
    wr_uart = 1'b1;
    w_data  = d;
    @(posedge clk); #1;
    wr_uart = 1'b0;
  endtask

  // Captures one 10-bit frame from tx (bit 0 = start), sampling mid-bit
  task automatic tx_capture(input int bit_clks, output logic [9:0] frame, output bit ok);
    int n = 0;
    frame = '0;
    ok = 1'b0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) return;
    ok = 1'b1;
    repeat (bit_clks / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      frame[i] = tx;
      if (i < 9) repeat (bit_clks) @(negedge clk);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic b);
    if (sel) p_rx = b;
    else     rx = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx_frame(input bit sel, input logic [7:0] d, input bit use_par,
                                input logic par_bit, input logic stop_bit);
    @(posedge clk); #1;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, par_bit);
    drive_bit(sel, stop_bit);
    drive_bit(sel, 1'b1);
  endtask

  // Waits for a word, compares it against the scoreboard head, then pops it
  task automatic read_rx(input bit sel);
    int n = 0;
    logic e;
    logic [31:0] exp_w;
    @(negedge clk);
    e = sel ? p_rx_empty : rx_empty;
    while (e && n < 4000) begin
      @(negedge clk);
      n++;
      e = sel ? p_rx_empty : rx_empty;
    end
    check("rx_wait_timeout", 32'(e), 32'd0);
    if (e) return;
    if ((sel ? p_exp_q.size() : exp_q.size()) == 0) begin
      check("sb_unexpected_word", 32'd1, 32'd0);
      return;
    end
    exp_w = sel ? p_exp_q.pop_front() : exp_q.pop_front();
    check("r_data",     32'(sel ? p_r_data : r_data), 32'(exp_w[7:0]));
    check("parity_err", 32'(sel ? p_parity_err : parity_err), 32'(exp_w[8]));
    check("frame_err",  32'(sel ? p_frame_err : frame_err), 32'(exp_w[9]));
    @(posedge clk); #1;
    if (sel) p_rd_uart = 1'b1;
    else     rd_uart = 1'b1;
    @(posedge clk); #1;
    p_rd_uart = 1'b0;
    rd_uart   = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  frame;
    bit          ok;
    logic [7:0]  d;
    int          lat;
    int          lows;
    int          n;
    logic [7:0]  words[17];

    rst = 1'b0;
    baud_div = 16'd0; p_baud_div = 16'd0;
    loopback = 1'b1;  p_loopback = 1'b0;
    wr_uart = 1'b0;   p_wr_uart = 1'b0;
    w_data = '0;      p_w_data = '0;
    rx = 1'b1;        p_rx = 1'b1;
    rd_uart = 1'b0;   p_rd_uart = 1'b0;
    clr_err = 1'b0;   p_clr_err = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_r_data", 32'(r_data), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_p_rx_empty", 32'(p_rx_empty), 32'd1);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // 1: loopback single word, frame shape and RX latency
    d = 8'd94;
    exp_q.push_back({22'd0, 1'b0, 1'b0, d});
    write_word(d);
    fork
      begin
        tx_capture(16, frame, ok);
        check("t1_tx_started", 32'(ok), 32'd1);
        check("t1_tx_frame", 32'(frame), 32'({1'b1, d, 1'b0}));
      end
      begin
        lat = 1;
        @(negedge clk);
        while (rx_empty && lat < 400) begin
          @(negedge clk);
          lat++;
        end
        check("t1_rx_latency_window", 32'(lat >= 140 && lat <= 175), 32'd1);
      end
    join
    read_rx(1'b0);
    @(negedge clk);
    check("t1_rx_empty_after_rd", 32'(rx_empty), 32'd1);

    // 2: external pins, slow baud, fill TX FIFO past full
    loopback = 1'b0;
    baud_div = 16'd10;
    repeat (30) @(posedge clk);
    for (int i = 0; i < 17; i++) words[i] = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      wr_uart = 1'b1;
      w_data  = (i < 17) ? words[i] : 8'hEE;
      @(posedge clk); #1;
      if (i == 15) check("t2_tx_full_after_16", 32'(tx_full), 32'd0);
      if (i == 16) check("t2_tx_full_after_17", 32'(tx_full), 32'd1);
    end
    wr_uart = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tx_capture(176, frame, ok);
      check("t2_tx_started", 32'(ok), 32'd1);
      check("t2_tx_frame", 32'(frame), 32'({1'b1, words[i], 1'b0}));
    end
    lows = 0;
    repeat (3520) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    check("t2_no_18th_frame", 32'(lows), 32'd0);
    check("t2_tx_full_drained", 32'(tx_full), 32'd0);
    check("t2_rx_idle_empty", 32'(rx_empty), 32'd1);
    baud_div = 16'd0;
    repeat (30) @(posedge clk);

    // 3: even parity instance, bad then good parity
    d = 8'hA5;
    p_exp_q.push_back({22'd0, 1'b0, 1'b1, d});
    drive_rx_frame(1'b1, d, 1'b1, ~(^d), 1'b1);
    d = 8'h3E;
    p_exp_q.push_back({22'd0, 1'b0, 1'b0, d});
    drive_rx_frame(1'b1, d, 1'b1, ^d, 1'b1);
    read_rx(1'b1);
    read_rx(1'b1);

    // 4: framing error, glitch reject, recovery
    d = 8'h3C;
    exp_q.push_back({22'd0, 1'b1, 1'b0, d});
    drive_rx_frame(1'b0, d, 1'b0, 1'b0, 1'b0);
    read_rx(1'b0);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t4_glitch_rejected", 32'(rx_empty), 32'd1);
    d = 8'h5A;
    exp_q.push_back({22'd0, 1'b0, 1'b0, d});
    drive_rx_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
    read_rx(1'b0);

    // 5: overrun with 17 loopback frames and no reads
    loopback = 1'b1;
    repeat (20) @(posedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      wr_uart = 1'b1;
      w_data  = 8'($urandom_range(0, 255));
      if (i < 16) exp_q.push_back({24'd0, w_data});
      @(posedge clk); #1;
    end
    wr_uart = 1'b0;
    n = 0;
    @(negedge clk);
    while (!overrun && n < 3400) begin
      @(negedge clk);
      n++;
    end
    check("t5_overrun_set", 32'(overrun), 32'd1);
    repeat (200) @(negedge clk);
    for (int i = 0; i < 16; i++) read_rx(1'b0);
    @(negedge clk);
    check("t5_rx_empty_after_16", 32'(rx_empty), 32'd1);
    check("t5_overrun_sticky", 32'(overrun), 32'd1);
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("t5_overrun_cleared", 32'(overrun), 32'd0);

    // 6: async reset mid-frame, then normal transmit
    write_word(8'h00);
    repeat (60) @(negedge clk);
    check("t6_tx_low_mid_frame", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("t6_tx_high_in_reset", 32'(tx), 32'd1);
    check("t6_rx_empty_in_reset", 32'(rx_empty), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rx_empty_after", 32'(rx_empty), 32'd1);
    check("t6_tx_full_after", 32'(tx_full), 32'd0);
    check("t6_overrun_after", 32'(overrun), 32'd0);
    d = 8'h81;
    exp_q.push_back({24'd0, d});
    write_word(d);
    fork
      begin
        tx_capture(16, frame, ok);
        check("t6_tx_started", 32'(ok), 32'd1);
        check("t6_tx_frame", 32'(frame), 32'({1'b1, d, 1'b0}));
      end
      read_rx(1'b0);
    join
    repeat (40) @(negedge clk);
    check("sb_leftover", 32'(exp_q.size() + p_exp_q.size()), 32'd0);
    check("final_rx_empty", 32'(rx_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
